// File: rtl/rom_adder_table_writer.sv
// rtl/rom_adder_table_writer.sv - fills the ROM-adder table RAM with a+b and optionally reads it back to self-check.
module rom_adder_table_writer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 9,
    parameter bit VERIFY     = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic [2*ADDR_WIDTH-1:0] mem_addr,
    output logic                    mem_wr_en,
    output logic [DATA_WIDTH-1:0]   mem_wr_data,
    input  logic                    mem_wr_ready,
    output logic                    mem_rd_en,
    input  logic [DATA_WIDTH-1:0]   mem_rd_data,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [2*ADDR_WIDTH:0]   err_count,
    output logic [2*ADDR_WIDTH-1:0] err_addr
);

    localparam int AW2 = 2 * ADDR_WIDTH;
    localparam logic [AW2-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t         state;
    logic           chk_valid;
    logic [AW2-1:0] chk_addr;
    logic           rd_mismatch;

    function automatic logic [DATA_WIDTH-1:0] entry(input logic [AW2-1:0] addr);
        logic [DATA_WIDTH-1:0] word;
        logic [ADDR_WIDTH:0]   sum;
        sum  = {1'b0, addr[AW2-1:ADDR_WIDTH]} + {1'b0, addr[ADDR_WIDTH-1:0]};
        word = '0;
        word[ADDR_WIDTH:0] = sum;
        return word;
    endfunction

    // The write word follows the registered address, so a stalled write keeps its data stable.
    assign mem_wr_data = entry(mem_addr);

    // Read data lands one cycle after the strobe; chk_* remember which address it belongs to.
    assign rd_mismatch = chk_valid && (mem_rd_data != entry(chk_addr));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_count <= '0;
            err_addr  <= '0;
            chk_valid <= 1'b0;
            chk_addr  <= '0;
        end else begin
            chk_valid <= mem_rd_en;
            chk_addr  <= mem_addr;

            if (rd_mismatch) begin
                err_count <= err_count + 1'b1;
                if (!error) begin
                    error    <= 1'b1;
                    err_addr <= chk_addr;
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= WRITE;
                        mem_addr  <= '0;
                        mem_wr_en <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        err_count <= '0;
                        err_addr  <= '0;
                    end
                end
                WRITE: begin
                    if (mem_wr_ready) begin
                        mem_addr <= mem_addr + 1'b1;
                        if (mem_addr == LAST_ADDR) begin
                            mem_wr_en <= 1'b0;
                            if (VERIFY) begin
                                state     <= READ;
                                mem_rd_en <= 1'b1;
                            end else begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                READ: begin
                    mem_addr <= mem_addr + 1'b1;
                    if (mem_addr == LAST_ADDR) begin
                        state     <= DRAIN;
                        mem_rd_en <= 1'b0;
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
